// File: rtl/ram_bitshift_engine.sv
// ram_bitshift_engine: shifts/rotates each RAM row by one bit through a strobed single-port RAM (clk/rst, start/dir/rotate/first_col in, ram_* bus, busy/done status)
module ram_bitshift_engine #(
  parameter int DW = 8,
  parameter int COLS = 8,
  parameter int ROWS = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   dir,
  input  logic                                   rotate,
  input  logic [$clog2(COLS)-1:0]                first_col,
  input  logic [DW-1:0]                          ram_dout,
  output logic                                   ram_clk,
  output logic                                   ram_we,
  output logic [$clog2(COLS)+$clog2(ROWS)-1:0]   ram_addr,
  output logic [DW-1:0]                          ram_din,
  output logic                                   busy,
  output logic                                   done
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  typedef enum logic [3:0] {IDLE, PRE_HI, PRE_LO, RD_HI, RD_LO, WE_SET, WR_HI, WR_LO, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] col, fc_q, last_col, first_c, acol;
  logic [RW-1:0] row;
  logic dir_q, rot_q, carry, col_end, row_end, out_bit;
  logic [DW-1:0] shifted;
  assign last_col = dir_q ? fc_q : '1;
  assign first_c = dir_q ? '1 : fc_q;
  assign col_end = col == last_col;
  assign row_end = row == '1;
  assign acol = (state == PRE_HI || state == PRE_LO) ? last_col : col;
  assign ram_addr = {~acol, row};
  assign shifted = dir_q ? {carry, ram_dout[DW-1:1]} : {ram_dout[DW-2:0], carry};
  assign out_bit = dir_q ? ram_dout[0] : ram_dout[DW-1];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (rotate ? PRE_HI : RD_HI) : IDLE;
      PRE_HI:  state_n = PRE_LO;
      PRE_LO:  state_n = RD_HI;
      RD_HI:   state_n = RD_LO;
      RD_LO:   state_n = WE_SET;
      WE_SET:  state_n = WR_HI;
      WR_HI:   state_n = WR_LO;
      WR_LO:   state_n = !col_end ? RD_HI : !row_end ? (rot_q ? PRE_HI : RD_HI) : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_clk <= 1'b0;
      ram_we <= 1'b0;
      ram_din <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      carry <= 1'b0;
      row <= '0;
      col <= '0;
      dir_q <= 1'b0;
      rot_q <= 1'b0;
      fc_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dir_q <= dir;
          rot_q <= rotate;
          fc_q <= first_col;
          busy <= 1'b1;
          row <= '0;
          col <= dir ? '1 : first_col;
          carry <= 1'b0;
        end
        PRE_HI, RD_HI, WR_HI: ram_clk <= 1'b1;
        PRE_LO: begin
          ram_clk <= 1'b0;
          carry <= out_bit;
        end
        RD_LO: begin
          ram_clk <= 1'b0;
          ram_din <= shifted;
        end
        WE_SET: begin
          carry <= out_bit;
          ram_we <= 1'b1;
        end
        WR_LO: begin
          ram_clk <= 1'b0;
          ram_we <= 1'b0;
          if (!col_end) col <= dir_q ? col - 1'b1 : col + 1'b1;
          else if (!row_end) begin
            row <= row + 1'b1;
            col <= first_c;
            carry <= 1'b0;
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_bitshift_engine.sv
// tb_ram_bitshift_engine: scoreboard bench for ram_bitshift_engine with a behavioural RAM
module tb_ram_bitshift_engine;
  localparam int ROWS = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, dir = 1'b0, rotate = 1'b0;
  logic [2:0] first_col = '0;
  logic [7:0] ram_dout = '0, ram_din, ram_addr;
  logic ram_clk, ram_we, busy, done;
  logic [7:0] mem [256];
  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];
  logic [7:0] wlog[$];
  int n_tests = 0, n_fail = 0, cyc = 0, n_rd = 0, n_wr = 0;
  logic rc_prev = 1'b0;

  ram_bitshift_engine dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .rotate(rotate), .first_col(first_col),
    .ram_dout(ram_dout), .ram_clk(ram_clk), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge ram_clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else ram_dout <= mem[ram_addr];
  end

  function automatic logic [7:0] pa(input int c, input int r);
    return 8'((7 - c) * 32 + r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (ram_clk && !rc_prev) begin
      if (ram_we) begin
        n_wr++;
        wlog.push_back(ram_addr);
        if (exp_q.size() == 0) chk("unexpected_write", {ram_addr, ram_din}, 16'hxxxx);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", ram_addr, e.a);
          chk("wr_data", ram_din, e.d);
        end
      end else n_rd++;
    end
    rc_prev = ram_clk;
  end

  task automatic model_push(input bit d, input bit r, input int fc);
    int n, i;
    logic [63:0] ob, nb;
    wr_t e;
    n = 8 - fc;
    for (int row = 0; row < ROWS; row++) begin
      ob = '0;
      nb = '0;
      for (int k = 0; k < n; k++) ob[k*8 +: 8] = mem[pa(fc + k, row)];
      for (int g = 0; g < n * 8; g++)
        if (!d) nb[g] = (g == 0) ? (r & ob[n*8-1]) : ob[g-1];
        else nb[g] = (g == n * 8 - 1) ? (r & ob[0]) : ob[g+1];
      for (int k = 0; k < n; k++) begin
        i = d ? n - 1 - k : k;
        e.a = pa(fc + i, row);
        e.d = nb[i*8 +: 8];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_op(input bit d, input bit r, input int fc, input int poke, input string nm);
    int n, s, dones, rd0, wr0;
    n = 8 - fc;
    model_push(d, r, fc);
    rd0 = n_rd;
    wr0 = n_wr;
    dir = d;
    rotate = r;
    first_col = fc[2:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    chk({nm, "_busy_start"}, busy, 1);
    dones = 0;
    for (int i = 1; i < 5000; i++) begin
      if (poke >= 0 && i >= poke) start = 1'b1;
      @(negedge clk);
      if (done) begin
        dones++;
        break;
      end
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_latency"}, cyc - s, ROWS * (5 * n + 2 * r) + 1);
    chk({nm, "_busy_at_done"}, busy, 0);
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_done_pulses"}, dones, 1);
    chk({nm, "_pending_writes"}, exp_q.size(), 0);
    chk({nm, "_reads"}, n_rd - rd0, ROWS * (n + r));
    chk({nm, "_writes"}, n_wr - wr0, ROWS * n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, acts;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
    repeat (3) @(negedge clk);
    chk("rst_addr", ram_addr, 8'hE0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_clk", ram_clk, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_din", ram_din, 0);
    rst = 1'b0;
    @(negedge clk);

    mem[pa(4, 0)] = 8'h81; mem[pa(5, 0)] = 8'h80; mem[pa(6, 0)] = 8'h01; mem[pa(7, 0)] = 8'hFF;
    wlog.delete();
    run_op(0, 0, 4, -1, "left_fc4");
    chk("r0c4", mem[pa(4, 0)], 8'h02);
    chk("r0c5", mem[pa(5, 0)], 8'h01);
    chk("r0c6", mem[pa(6, 0)], 8'h03);
    chk("r0c7", mem[pa(7, 0)], 8'hFE);
    chk("waddr0", wlog[0], 8'h60);
    chk("waddr1", wlog[1], 8'h40);
    chk("waddr2", wlog[2], 8'h20);
    chk("waddr3", wlog[3], 8'h00);
    chk("waddr4", wlog[4], 8'h61);

    mem[pa(7, 0)] = 8'h02; mem[pa(6, 0)] = 8'h01;
    run_op(1, 1, 6, -1, "right_rot_fc6");
    chk("rot_r0c7", mem[pa(7, 0)], 8'h81);
    chk("rot_r0c6", mem[pa(6, 0)], 8'h00);

    mem[pa(7, 0)] = 8'h80; mem[pa(4, 1)] = 8'h00;
    run_op(0, 0, 4, -1, "row_isolation");
    chk("r1c4_no_carry", mem[pa(4, 1)], 8'h00);

    mem[pa(7, 0)] = 8'h80;
    run_op(0, 1, 7, -1, "single_word_rot");
    chk("single_rot", mem[pa(7, 0)], 8'h01);

    run_op(0, 0, 4, 65, "start_ignored");

    model_push(0, 0, 4);
    dir = 1'b0; rotate = 1'b0; first_col = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    repeat (32) @(negedge clk);
    chk("we_set_timing", cyc - s, 32);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ram_clk", ram_clk, 0);
    chk("mid_rst_left_writes", exp_q.size(), 128 - 6);
    exp_q.delete();
    acts = n_rd + n_wr;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_strobes", n_rd + n_wr - acts, 0);
    run_op(1, 0, 0, -1, "after_reset_full");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
